karatsuba_seq_mult: RTL and testbench

//  Sequential 8x8 unsigned Karatsuba multiplier. One shared 4x4/5x5 product ROM

---
 rtl/karatsuba_seq_mult.sv | 191 +++++++++++++++++++
 tb/tb_karatsuba_seq_mult.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_seq_mult.sv
// -----------------------------------------------------------------------------
// karatsuba_seq_mult
//
// Sequential 8x8 unsigned Karatsuba multiplier. A single external product ROM
// (address {a[4:0], b[4:0]}, data a*b) is used three times per operation:
//   A = Xl*Yl,  B = Xh*Yh,  C = (Xl+Xh)*(Yl+Yh)
// and the result is combined as P = (B << 8) + ((C - A - B) << 4) + A.
//
// Flow: IDLE -> LK_A -> LK_B -> LK_C -> CMB -> OUT -> IDLE
//   ROM_LAT = 0 : combinational ROM, each lookup state lasts one cycle.
//   ROM_LAT = 1 : registered ROM, each lookup state lasts two cycles with the
//                 address held; data is taken at the end of the second cycle.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   X/Y valid
//   in_ready   out  1   high only in IDLE
//   X, Y       in   8   operands, sampled on the accept edge
//   rom_addr   out  10  product ROM address, 0 outside the lookup states
//   rom_data   in   10  product ROM data
//   out_valid  out  1   P valid (OUT state)
//   out_ready  in   1   consumer accepts P
//   P          out  16  product, held until the next combine step
//   busy       out  1   operation in flight
// -----------------------------------------------------------------------------
module karatsuba_seq_mult #(
    parameter int ROM_LAT = 0   // 0 = combinational ROM, 1 = registered ROM
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  X,
    input  logic [7:0]  Y,
    output logic [9:0]  rom_addr,
    input  logic [9:0]  rom_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] P,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LK_A,
        S_LK_B,
        S_LK_C,
        S_CMB,
        S_OUT
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_x;
    logic [7:0]  r_y;
    logic [7:0]  r_a;       // Xl*Yl, at most 225
    logic [7:0]  r_b;       // Xh*Yh, at most 225
    logic [9:0]  r_c;       // (Xl+Xh)*(Yl+Yh), at most 900
    logic [15:0] r_p;
    logic        r_wait;    // set during the first cycle of a registered-ROM lookup

    logic        w_lookup;
    logic        w_cap;
    logic [4:0]  w_sum_x;
    logic [4:0]  w_sum_y;
    logic [15:0] w_m;
    logic [15:0] w_p;

    assign w_sum_x = {1'b0, r_x[3:0]} + {1'b0, r_x[7:4]};
    assign w_sum_y = {1'b0, r_y[3:0]} + {1'b0, r_y[7:4]};

    // With a registered ROM the data for the held address appears one cycle
    // late, so the lookup state captures only on its second cycle.
    assign w_cap    = (ROM_LAT == 0) ? 1'b1 : r_wait;
    assign w_lookup = (r_state == S_LK_A) || (r_state == S_LK_B) || (r_state == S_LK_C);

    // Middle Karatsuba term; C >= A + B always holds, so this never wraps.
    assign w_m = {6'd0, r_c} - {8'd0, r_a} - {8'd0, r_b};
    assign w_p = {r_b, 8'h00} + (w_m << 4) + {8'd0, r_a};

    assign P = r_p;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        rom_addr    = 10'd0;
        busy        = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_LK_A;
                end
            end
            S_LK_A: begin
                rom_addr = {1'b0, r_x[3:0], 1'b0, r_y[3:0]};
                if (w_cap) begin
                    w_state_nxt = S_LK_B;
                end
            end
            S_LK_B: begin
                rom_addr = {1'b0, r_x[7:4], 1'b0, r_y[7:4]};
                if (w_cap) begin
                    w_state_nxt = S_LK_C;
                end
            end
            S_LK_C: begin
                rom_addr = {w_sum_x, w_sum_y};
                if (w_cap) begin
                    w_state_nxt = S_CMB;
                end
            end
            S_CMB: begin
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= 8'd0;
            r_y    <= 8'd0;
            r_a    <= 8'd0;
            r_b    <= 8'd0;
            r_c    <= 10'd0;
            r_p    <= 16'd0;
            r_wait <= 1'b0;
        end else begin
            if (r_state == S_IDLE && in_valid) begin
                r_x <= X;
                r_y <= Y;
            end

            // Toggles 0 -> 1 -> 0 across each two-cycle lookup; stays 0 for a
            // combinational ROM.
            if (ROM_LAT != 0 && w_lookup) begin
                r_wait <= ~r_wait;
            end else begin
                r_wait <= 1'b0;
            end

            if (w_cap) begin
                case (r_state)
                    S_LK_A:  r_a <= rom_data[7:0];
                    S_LK_B:  r_b <= rom_data[7:0];
                    S_LK_C:  r_c <= rom_data;
                    default: ;
                endcase
            end

            if (r_state == S_CMB) begin
                r_p <= w_p;
            end
        end
    end

endmodule

// File: tb/tb_karatsuba_seq_mult.sv
// -----------------------------------------------------------------------------
// tb_karatsuba_seq_mult
//
// Two instances share clock and reset: dut0 with a combinational product ROM
// (ROM_LAT=0) and dut1 with a registered product ROM (ROM_LAT=1). Directed
// operand pairs with hand-computed products, protocol checks around every
// operation, and a randomised-gap sweep on the registered-ROM instance.
// -----------------------------------------------------------------------------
module tb_karatsuba_seq_mult;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [7:0]  X         [2];
    logic [7:0]  Y         [2];
    logic [9:0]  rom_addr  [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [15:0] P         [2];
    logic        busy      [2];

    logic [9:0]  rom_data_0;
    logic [9:0]  rom_data_1;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [9:0]  addr_log [8];

    always #5 clk = ~clk;

    // Product ROM models: combinational for dut0, one-cycle registered for dut1.
    assign rom_data_0 = {5'd0, rom_addr[0][9:5]} * {5'd0, rom_addr[0][4:0]};

    always @(posedge clk) begin
        rom_data_1 <= {5'd0, rom_addr[1][9:5]} * {5'd0, rom_addr[1][4:0]};
    end

    karatsuba_seq_mult #(.ROM_LAT(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .X         (X[0]),
        .Y         (Y[0]),
        .rom_addr  (rom_addr[0]),
        .rom_data  (rom_data_0),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .P         (P[0]),
        .busy      (busy[0])
    );

    karatsuba_seq_mult #(.ROM_LAT(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .X         (X[1]),
        .Y         (Y[1]),
        .rom_addr  (rom_addr[1]),
        .rom_data  (rom_data_1),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .P         (P[1]),
        .busy      (busy[1])
    );

    // One complete operation on instance d. Drives the accept, measures the
    // edges from accept to the first out_valid cycle, optionally stalls in OUT
    // for 'stall' cycles, then completes the handshake.
    task automatic run_op(input int d, input logic [7:0] x, input logic [7:0] y,
                          input int gap, input int stall, input bit keep_valid,
                          output int lat, output logic [15:0] p);
        logic [15:0] p_first;
        repeat (gap) @(negedge clk);
        n_tests++;
        if (in_ready[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_in_ready dut%0d: got %b expected 1", d, in_ready[d]);
        end
        in_valid[d] = 1'b1;
        X[d] = x;
        Y[d] = y;
        @(negedge clk);
        // Operand changes after acceptance must not matter.
        in_valid[d] = keep_valid;
        X[d] = ~x;
        Y[d] = y ^ 8'h5a;
        n_tests++;
        if (busy[d] !== 1'b1 || in_ready[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_accept dut%0d: busy=%b in_ready=%b expected 1/0",
                     d, busy[d], in_ready[d]);
        end
        lat = 0;
        while (out_valid[d] !== 1'b1 && lat < 40) begin
            if (lat < 8) addr_log[lat] = rom_addr[d];
            @(negedge clk);
            lat++;
        end
        in_valid[d] = 1'b0;
        p = P[d];
        if (lat >= 40) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout dut%0d: no out_valid within 40 cycles", d);
            return;
        end
        n_tests++;
        if (rom_addr[d] !== 10'd0) begin
            n_fail++;
            $display("FAIL rom_addr_out dut%0d: got %h expected 000", d, rom_addr[d]);
        end
        p_first = P[d];
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid[d] !== 1'b1 || P[d] !== p_first || in_ready[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold dut%0d cyc %0d: out_valid=%b P=%h in_ready=%b expected 1/%h/0",
                         d, i, out_valid[d], P[d], in_ready[d], p_first);
            end
        end
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
        n_tests++;
        if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1 || busy[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL after_handshake dut%0d: out_valid=%b in_ready=%b busy=%b expected 0/1/0",
                     d, out_valid[d], in_ready[d], busy[d]);
        end
    endtask

    task automatic test_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || P[d] !== 16'h0000 ||
                rom_addr[d] !== 10'h000 || busy[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: in_ready=%b out_valid=%b P=%h rom_addr=%h busy=%b",
                         d, in_ready[d], out_valid[d], P[d], rom_addr[d], busy[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero();
        int lat;
        logic [15:0] p;
        run_op(0, 8'h00, 8'h00, 1, 0, 1'b0, lat, p);
        n_tests++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL zero_latency: got %0d expected 4", lat);
        end
        n_tests++;
        if (p !== 16'h0000) begin
            n_fail++;
            $display("FAIL zero_product: got %h expected 0000", p);
        end
        n_tests++;
        if (dut0.r_a !== 8'd0 || dut0.r_b !== 8'd0 || dut0.r_c !== 10'd0) begin
            n_fail++;
            $display("FAIL zero_abc: A=%h B=%h C=%h expected 0/0/0", dut0.r_a, dut0.r_b, dut0.r_c);
        end
    endtask

    task automatic test_max();
        int lat;
        logic [15:0] p;
        run_op(0, 8'hFF, 8'hFF, 0, 0, 1'b0, lat, p);
        n_tests++;
        if (addr_log[0] !== 10'h1EF || addr_log[1] !== 10'h1EF || addr_log[2] !== 10'h3DE) begin
            n_fail++;
            $display("FAIL max_addr_seq: got %h %h %h expected 1ef 1ef 3de",
                     addr_log[0], addr_log[1], addr_log[2]);
        end
        n_tests++;
        if (p !== 16'hFE01) begin
            n_fail++;
            $display("FAIL max_product: got %h expected fe01", p);
        end
        // A = B = 15*15 = 0xE1, C = 30*30 = 900 = 0x384
        n_tests++;
        if (dut0.r_a !== 8'hE1 || dut0.r_b !== 8'hE1 || dut0.r_c !== 10'h384) begin
            n_fail++;
            $display("FAIL max_abc: A=%h B=%h C=%h expected e1/e1/384", dut0.r_a, dut0.r_b, dut0.r_c);
        end
    endtask

    task automatic test_patterns();
        logic [7:0]  xs [4] = '{8'h12, 8'hF0, 8'hA5, 8'h80};
        logic [7:0]  ys [4] = '{8'h34, 8'h0F, 8'h5A, 8'h80};
        logic [15:0] ex [4] = '{16'h03A8, 16'h0E10, 16'h3A02, 16'h4000};
        int lat;
        logic [15:0] p;
        for (int i = 0; i < 4; i++) begin
            run_op(0, xs[i], ys[i], 0, 0, 1'b0, lat, p);
            n_tests++;
            if (p !== ex[i]) begin
                n_fail++;
                $display("FAIL pattern_%0d %h*%h: got %h expected %h", i, xs[i], ys[i], p, ex[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [15:0] p;
        run_op(0, 8'h0F, 8'h0F, 0, 10, 1'b0, lat, p);
        n_tests++;
        if (p !== 16'h00E1) begin
            n_fail++;
            $display("FAIL backpressure_product: got %h expected 00e1", p);
        end
        // Consumer ready before OUT: no effect on latency or result.
        out_ready[0] = 1'b1;
        run_op(0, 8'h10, 8'h10, 0, 0, 1'b0, lat, p);
        n_tests++;
        if (lat != 4 || p !== 16'h0100) begin
            n_fail++;
            $display("FAIL early_ready: lat=%0d P=%h expected 4/0100", lat, p);
        end
    endtask

    task automatic test_ignore_busy();
        int lat;
        logic [15:0] p;
        // in_valid held high with other operands during the whole operation.
        run_op(0, 8'hFF, 8'h01, 0, 2, 1'b1, lat, p);
        n_tests++;
        if (p !== 16'h00FF) begin
            n_fail++;
            $display("FAIL ignore_busy: got %h expected 00ff", p);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [15:0] p;
        run_op(0, 8'h07, 8'h09, 0, 0, 1'b0, lat, p);
        n_tests++;
        if (p !== 16'h003F) begin
            n_fail++;
            $display("FAIL b2b_first: got %h expected 003f", p);
        end
        run_op(0, 8'h2B, 8'h03, 0, 0, 1'b0, lat, p);
        n_tests++;
        if (p !== 16'h0081) begin
            n_fail++;
            $display("FAIL b2b_second: got %h expected 0081", p);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        logic [15:0] p;
        @(negedge clk);
        in_valid[0] = 1'b1;
        X[0] = 8'h77;
        Y[0] = 8'h21;
        @(negedge clk);          // accepted, now in LK_A
        in_valid[0] = 1'b0;
        @(negedge clk);          // now in LK_B
        n_tests++;
        if (rom_addr[0] !== 10'h0E2) begin
            n_fail++;
            $display("FAIL mid_op_lk_b_addr: got %h expected 0e2", rom_addr[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || P[0] !== 16'h0000 ||
            rom_addr[0] !== 10'h000 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_op_reset: in_ready=%b out_valid=%b P=%h rom_addr=%h busy=%b",
                     in_ready[0], out_valid[0], P[0], rom_addr[0], busy[0]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL no_partial_result cyc %0d: out_valid=%b busy=%b expected 0/0",
                         i, out_valid[0], busy[0]);
            end
        end
        run_op(0, 8'h03, 8'h05, 0, 0, 1'b0, lat, p);
        n_tests++;
        if (p !== 16'h000F) begin
            n_fail++;
            $display("FAIL after_reset_product: got %h expected 000f", p);
        end
    endtask

    task automatic test_rom_lat1();
        logic [7:0]  xs [6] = '{8'hFF, 8'h00, 8'h12, 8'hF0, 8'h80, 8'hA5};
        logic [7:0]  ys [6] = '{8'hFF, 8'h9C, 8'h34, 8'h0F, 8'h80, 8'h5A};
        logic [15:0] ex [6] = '{16'hFE01, 16'h0000, 16'h03A8, 16'h0E10, 16'h4000, 16'h3A02};
        int lat;
        logic [15:0] p;
        for (int i = 0; i < 6; i++) begin
            run_op(1, xs[i], ys[i], 0, i % 3, 1'b0, lat, p);
            if (i == 0) begin
                n_tests++;
                if (addr_log[0] !== 10'h1EF || addr_log[1] !== 10'h1EF || addr_log[2] !== 10'h1EF ||
                    addr_log[3] !== 10'h1EF || addr_log[4] !== 10'h3DE || addr_log[5] !== 10'h3DE) begin
                    n_fail++;
                    $display("FAIL lat1_addr_hold: got %h %h %h %h %h %h",
                             addr_log[0], addr_log[1], addr_log[2],
                             addr_log[3], addr_log[4], addr_log[5]);
                end
            end
            n_tests++;
            if (lat != 7 || p !== ex[i]) begin
                n_fail++;
                $display("FAIL lat1_directed_%0d %h*%h: lat=%0d P=%h expected 7/%h",
                         i, xs[i], ys[i], lat, p, ex[i]);
            end
        end
    endtask

    task automatic test_rom_lat1_sweep();
        int lat;
        logic [15:0] p;
        logic [15:0] ex;
        logic [7:0]  x;
        logic [7:0]  y;
        int          errs = 0;
        for (int i = 0; i < 300; i++) begin
            x  = 8'($urandom_range(0, 255));
            y  = 8'($urandom_range(0, 255));
            ex = {8'd0, x} * {8'd0, y};
            run_op(1, x, y, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, lat, p);
            n_tests++;
            if (lat != 7 || p !== ex) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL lat1_sweep_%0d %h*%h: lat=%0d P=%h expected 7/%h",
                             i, x, y, lat, p, ex);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
            X[d]         = 8'h00;
            Y[d]         = 8'h00;
        end

        test_reset();
        test_zero();
        test_max();
        test_patterns();
        test_backpressure();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_op();
        test_rom_lat1();
        test_rom_lat1_sweep();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
